mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_arb_pkg.sv | 21 ++
 rtl/rr_arbiter2.sv | 20 ++
 rtl/mem_port_arbiter.sv | 211 +++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 417 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared FSM encoding and requester IDs for the memory port arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_RESP = 2'd3
  } arb_state_t;

  // Requester IDs double as bit positions in the two-entry request/grant vectors.
  localparam logic ID_INSTR = 1'b0;
  localparam logic ID_DATA  = 1'b1;

  function automatic logic [1:0] id_onehot(input logic id);
    return (id == ID_DATA) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick between the instr and data sides.
// Latency: combinational; the caller registers the result.
// Backpressure: none; a tie goes to the side that was not granted last.
module rr_arbiter2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] grant
);

  // A sole request wins outright; on a tie the side not granted last wins.
  always_comb begin
    grant = req;
    if (req == 2'b11) begin
      grant = (last_grant == ID_INSTR) ? id_onehot(ID_DATA) : id_onehot(ID_INSTR);
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between I-cache refill, D-cache refill and D-cache writeback.
// Latency: grant registered one cycle after the request is seen in IDLE; done one cycle after MEM done.
// Backpressure: requests are level-held until done; one transaction in flight, aborted after TIMEOUT_CYCLES.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDRESS_WIDTH  = 32,
  parameter int BLOCK_WIDTH    = 512,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_rd_req,
  input  logic [ADDRESS_WIDTH-1:0] i_rd_addr,
  output logic                     i_rd_done,
  output logic [BLOCK_WIDTH-1:0]   i_rd_data,
  input  logic                     d_rd_req,
  input  logic [ADDRESS_WIDTH-1:0] d_rd_addr,
  output logic                     d_rd_done,
  output logic [BLOCK_WIDTH-1:0]   d_rd_data,
  input  logic                     d_wr_req,
  input  logic [ADDRESS_WIDTH-1:0] d_wr_addr,
  input  logic [BLOCK_WIDTH-1:0]   d_wr_data,
  input  logic [BLOCK_WIDTH-1:0]   d_wr_mask,
  output logic                     d_wr_done,
  output logic                     MEM_data_read_enable,
  output logic                     MEM_data_write_enable,
  output logic [ADDRESS_WIDTH-1:0] MEM_data_read_address,
  output logic [ADDRESS_WIDTH-1:0] MEM_data_write_address,
  output logic [BLOCK_WIDTH-1:0]   MEM_data_give,
  output logic [BLOCK_WIDTH-1:0]   MEM_data_mask,
  input  logic [BLOCK_WIDTH-1:0]   MEM_data_get,
  input  logic                     MEM_data_read_done,
  input  logic                     MEM_data_write_done,
  output logic                     busy,
  output logic                     timeout_err
);

  // Wait counter just wide enough to hold TIMEOUT_CYCLES-1, the last cycle we wait.
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT_CYCLES - 1);

  arb_state_t               state_q, state_d;
  logic                     last_grant_q, last_grant_d;
  logic                     owner_q, owner_d;
  logic [CW-1:0]            wait_q, wait_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [BLOCK_WIDTH-1:0]   wdata_q, wdata_d;
  logic [BLOCK_WIDTH-1:0]   mask_q, mask_d;
  logic [BLOCK_WIDTH-1:0]   i_rd_data_q, i_rd_data_d;
  logic [BLOCK_WIDTH-1:0]   d_rd_data_q, d_rd_data_d;
  logic                     rd_en_q, rd_en_d;
  logic                     wr_en_q, wr_en_d;
  logic                     i_rd_done_q, i_rd_done_d;
  logic                     d_rd_done_q, d_rd_done_d;
  logic                     d_wr_done_q, d_wr_done_d;
  logic                     busy_q, busy_d;
  logic                     tmo_q, tmo_d;

  logic [1:0] req_vec;
  logic [1:0] grant;

  // Writeback and refill from the D-cache compete as a single data-side candidate.
  always_comb begin
    req_vec           = 2'b00;
    req_vec[ID_INSTR] = i_rd_req;
    req_vec[ID_DATA]  = d_wr_req | d_rd_req;
  end

  rr_arbiter2 u_rr (
    .req        (req_vec),
    .last_grant (last_grant_q),
    .grant      (grant)
  );

  // Next-state logic: grant in IDLE, wait for the matching MEM done or timeout, pulse done in RESP.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    wait_d       = wait_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    mask_d       = mask_q;
    i_rd_data_d  = i_rd_data_q;
    d_rd_data_d  = d_rd_data_q;
    i_rd_done_d  = 1'b0;
    d_rd_done_d  = 1'b0;
    d_wr_done_d  = 1'b0;
    tmo_d        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (|grant) begin
          wait_d = '0;
          if (grant[ID_DATA]) begin
            last_grant_d = ID_DATA;
            owner_d      = ID_DATA;
            // Writeback first so a refill never reads stale memory for a dirty victim.
            if (d_wr_req) begin
              state_d = ST_WR;
              addr_d  = d_wr_addr;
              wdata_d = d_wr_data;
              mask_d  = d_wr_mask;
            end else begin
              state_d = ST_RD;
              addr_d  = d_rd_addr;
            end
          end else begin
            last_grant_d = ID_INSTR;
            owner_d      = ID_INSTR;
            state_d      = ST_RD;
            addr_d       = i_rd_addr;
          end
        end
      end

      ST_RD: begin
        if (MEM_data_read_done || (wait_q == WAIT_LAST)) begin
          state_d     = ST_RESP;
          i_rd_done_d = (owner_q == ID_INSTR);
          d_rd_done_d = (owner_q == ID_DATA);
          // A real completion wins over a coincident timeout.
          if (MEM_data_read_done) begin
            if (owner_q == ID_INSTR) begin
              i_rd_data_d = MEM_data_get;
            end else begin
              d_rd_data_d = MEM_data_get;
            end
          end else begin
            tmo_d = 1'b1;
          end
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end

      ST_WR: begin
        if (MEM_data_write_done || (wait_q == WAIT_LAST)) begin
          state_d     = ST_RESP;
          d_wr_done_d = 1'b1;
          tmo_d       = ~MEM_data_write_done;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    rd_en_d = (state_d == ST_RD);
    wr_en_d = (state_d == ST_WR);
    busy_d  = (state_d != ST_IDLE);
  end

  // State and registered outputs; reset drops any in-flight transaction without a done.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      last_grant_q <= ID_INSTR;
      owner_q      <= ID_INSTR;
      wait_q       <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      mask_q       <= '0;
      i_rd_data_q  <= '0;
      d_rd_data_q  <= '0;
      rd_en_q      <= 1'b0;
      wr_en_q      <= 1'b0;
      i_rd_done_q  <= 1'b0;
      d_rd_done_q  <= 1'b0;
      d_wr_done_q  <= 1'b0;
      busy_q       <= 1'b0;
      tmo_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      wait_q       <= wait_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      mask_q       <= mask_d;
      i_rd_data_q  <= i_rd_data_d;
      d_rd_data_q  <= d_rd_data_d;
      rd_en_q      <= rd_en_d;
      wr_en_q      <= wr_en_d;
      i_rd_done_q  <= i_rd_done_d;
      d_rd_done_q  <= d_rd_done_d;
      d_wr_done_q  <= d_wr_done_d;
      busy_q       <= busy_d;
      tmo_q        <= tmo_d;
    end
  end

  assign MEM_data_read_enable   = rd_en_q;
  assign MEM_data_write_enable  = wr_en_q;
  assign MEM_data_read_address  = addr_q;
  assign MEM_data_write_address = addr_q;
  assign MEM_data_give          = wdata_q;
  assign MEM_data_mask          = mask_q;
  assign i_rd_data              = i_rd_data_q;
  assign d_rd_data              = d_rd_data_q;
  assign i_rd_done              = i_rd_done_q;
  assign d_rd_done              = d_rd_done_q;
  assign d_wr_done              = d_wr_done_q;
  assign busy                   = busy_q;
  assign timeout_err            = tmo_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scenarios followed by randomized traffic against a queue-based reference model.
module tb_mem_port_arbiter;
  localparam int AW  = 32;
  localparam int BW  = 64;
  localparam int TMO = 8;
  localparam int NTX = 25;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic i_rd_req, d_rd_req, d_wr_req;
  logic [AW-1:0] i_rd_addr, d_rd_addr, d_wr_addr;
  logic [BW-1:0] d_wr_data, d_wr_mask;
  logic i_rd_done, d_rd_done, d_wr_done;
  logic [BW-1:0] i_rd_data, d_rd_data;
  logic MEM_data_read_enable, MEM_data_write_enable;
  logic [AW-1:0] MEM_data_read_address, MEM_data_write_address;
  logic [BW-1:0] MEM_data_give, MEM_data_mask, MEM_data_get;
  logic MEM_data_read_done, MEM_data_write_done;
  logic busy, timeout_err;

  mem_port_arbiter #(.ADDRESS_WIDTH(AW), .BLOCK_WIDTH(BW), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst),
    .i_rd_req(i_rd_req), .i_rd_addr(i_rd_addr), .i_rd_done(i_rd_done), .i_rd_data(i_rd_data),
    .d_rd_req(d_rd_req), .d_rd_addr(d_rd_addr), .d_rd_done(d_rd_done), .d_rd_data(d_rd_data),
    .d_wr_req(d_wr_req), .d_wr_addr(d_wr_addr), .d_wr_data(d_wr_data), .d_wr_mask(d_wr_mask),
    .d_wr_done(d_wr_done),
    .MEM_data_read_enable(MEM_data_read_enable), .MEM_data_write_enable(MEM_data_write_enable),
    .MEM_data_read_address(MEM_data_read_address), .MEM_data_write_address(MEM_data_write_address),
    .MEM_data_give(MEM_data_give), .MEM_data_mask(MEM_data_mask), .MEM_data_get(MEM_data_get),
    .MEM_data_read_done(MEM_data_read_done), .MEM_data_write_done(MEM_data_write_done),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Request levels as the DUT saw them at the most recent rising edge.
  logic snap_i = 1'b0, snap_dr = 1'b0, snap_dw = 1'b0;
  always @(posedge clk) begin
    snap_i  <= i_rd_req;
    snap_dr <= d_rd_req;
    snap_dw <= d_wr_req;
  end

  typedef struct {
    int            id;
    logic [BW-1:0] data;
    bit            tmo;
    int            cyc;
  } exp_t;
  exp_t sbq[$];

  // Reference-model state for the random phase.
  logic [AW-1:0] a_addr [3];
  logic [BW-1:0] wdat, wmask;
  logic [BW-1:0] ref_last [3];
  bit  ref_last_data;
  int  ref_owner = -1;
  bit  stop = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chkd(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [BW-1:0] rand_blk();
    logic [BW-1:0] r;
    r = '0;
    for (int i = 0; i < BW / 32; i++) r = {r[BW-33:0], $urandom()};
    return r;
  endfunction

  function automatic int done_who();
    int n;
    n = int'(i_rd_done) + int'(d_rd_done) + int'(d_wr_done);
    if (n == 0) return -1;
    if (n > 1) return 9;
    if (i_rd_done) return 0;
    if (d_rd_done) return 1;
    return 2;
  endfunction

  // Directed MEM responder: waits for an enable, answers in enabled cycle `lat`, returns what was seen.
  task automatic run_txn(input int lat, input logic [BW-1:0] rdat, input bit spur,
                         output int who, output int wcyc, output int ecyc, output logic [AW-1:0] addr,
                         output bit was_wr, output bit tmo, output logic [BW-1:0] give,
                         output logic [BW-1:0] mask);
    wcyc = 0;
    ecyc = 0;
    while (!(MEM_data_read_enable || MEM_data_write_enable) && wcyc < 50) begin
      @(negedge clk);
      wcyc++;
    end
    was_wr = MEM_data_write_enable;
    addr   = was_wr ? MEM_data_write_address : MEM_data_read_address;
    give   = MEM_data_give;
    mask   = MEM_data_mask;
    while ((MEM_data_read_enable || MEM_data_write_enable) && ecyc < 50) begin
      ecyc++;
      if (ecyc == lat) begin
        if (was_wr) MEM_data_write_done = 1'b1;
        else begin
          MEM_data_read_done = 1'b1;
          MEM_data_get       = rdat;
        end
      end else if (spur && ecyc == 2) begin
        if (was_wr) MEM_data_read_done = 1'b1;
        else        MEM_data_write_done = 1'b1;
      end
      @(negedge clk);
      MEM_data_read_done  = 1'b0;
      MEM_data_write_done = 1'b0;
    end
    who = done_who();
    tmo = timeout_err;
  endtask

  task automatic drive(input int id, input logic v);
    case (id)
      0: begin i_rd_addr = a_addr[0]; i_rd_req = v; end
      1: begin d_rd_addr = a_addr[1]; d_rd_req = v; end
      default: begin
        d_wr_addr = a_addr[2];
        d_wr_data = wdat;
        d_wr_mask = wmask;
        d_wr_req  = v;
      end
    endcase
  endtask

  function automatic bit done_of(input int id);
    case (id)
      0: return i_rd_done;
      1: return d_rd_done;
      default: return d_wr_done;
    endcase
  endfunction

  // Random requester: holds its request until its own done, sometimes drops it once granted.
  task automatic agent(input int id);
    int t;
    bit got, drop;
    for (int n = 0; n < NTX; n++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      a_addr[id] = $urandom() & 32'hFFFF_FFC0;
      if (id == 2) begin
        wdat  = rand_blk();
        wmask = rand_blk();
      end
      drive(id, 1'b1);
      drop = ($urandom_range(0, 4) == 0);
      got = 1'b0;
      t = 0;
      while (!got && t < 400) begin
        @(negedge clk);
        t++;
        if (done_of(id)) got = 1'b1;
        else if (drop && ref_owner == id) drive(id, 1'b0);
      end
      chk("agent_done_seen", int'(got), 1);
      drive(id, 1'b0);
    end
  endtask

  // Reference arbitration plus MEM responder; pushes the expected done into the scoreboard.
  task automatic mem_model();
    bit active = 1'b0, spur = 1'b0, prev_busy = 1'b0, en_on, ci, cd, pick_data, is_wr;
    int en = 0, lat = 0, id = -1;
    logic [BW-1:0] rdat;
    exp_t e;
    while (!stop) begin
      @(negedge clk);
      MEM_data_read_done  = 1'b0;
      MEM_data_write_done = 1'b0;
      en_on = MEM_data_read_enable | MEM_data_write_enable;
      if (busy && !prev_busy) begin
        ci = snap_i;
        cd = snap_dr | snap_dw;
        pick_data = (ci && cd) ? !ref_last_data : cd;
        chk("grant_has_requester", int'(ci || cd), 1);
        if (ci || cd) begin
          ref_last_data = pick_data;
          id = pick_data ? (snap_dw ? 2 : 1) : 0;
          is_wr = (id == 2);
          chk("grant_rd_enable", int'(MEM_data_read_enable), int'(!is_wr));
          chk("grant_wr_enable", int'(MEM_data_write_enable), int'(is_wr));
          chkd("grant_addr", BW'(is_wr ? MEM_data_write_address : MEM_data_read_address),
               BW'(a_addr[id]));
          if (is_wr) begin
            chkd("wr_give", MEM_data_give, wdat);
            chkd("wr_mask", MEM_data_mask, wmask);
          end
          lat  = $urandom_range(1, TMO + 2);
          spur = ($urandom_range(0, 3) == 0);
          rdat = rand_blk();
          en = 0;
          active = 1'b1;
          ref_owner = id;
        end
      end
      prev_busy = busy;
      chk("enable_matches_txn", int'(en_on), int'(active));
      if (active && !en_on) begin
        active = 1'b0;
        ref_owner = -1;
      end else if (active) begin
        en++;
        if (en == lat) begin
          if (is_wr) MEM_data_write_done = 1'b1;
          else begin
            MEM_data_read_done = 1'b1;
            MEM_data_get       = rdat;
          end
        end else if (spur && en == 1) begin
          if (is_wr) MEM_data_read_done = 1'b1;
          else       MEM_data_write_done = 1'b1;
        end
        if (en == lat || en == TMO) begin
          e.id  = id;
          e.tmo = (lat > TMO);
          e.cyc = cyc + 1;
          if (!is_wr && !e.tmo) ref_last[id] = rdat;
          e.data = is_wr ? '0 : ref_last[id];
          sbq.push_back(e);
          active = 1'b0;
          ref_owner = -1;
        end
      end
    end
  endtask

  // Scoreboard monitor: every done pulse must match the oldest expected completion.
  task automatic monitor();
    exp_t e;
    int who, nd;
    while (!stop) begin
      @(negedge clk);
      nd = int'(i_rd_done) + int'(d_rd_done) + int'(d_wr_done);
      if (nd != 0) begin
        who = done_who();
        chk("single_done", nd, 1);
        chk("busy_in_resp", int'(busy), 1);
        chk("sb_pending", int'(sbq.size() != 0), 1);
        if (sbq.size() != 0) begin
          e = sbq.pop_front();
          chk("done_requester", who, e.id);
          chk("done_cycle", cyc, e.cyc);
          chk("timeout_flag", int'(timeout_err), int'(e.tmo));
          if (e.id < 2) chkd("rd_data", (e.id == 0) ? i_rd_data : d_rd_data, e.data);
        end
      end else begin
        chk("no_tmo_without_done", int'(timeout_err), 0);
      end
    end
  endtask

  initial begin
    int who, wc, ec;
    logic [AW-1:0] ad;
    bit ww, tm;
    logic [BW-1:0] gv, mk, exp_i;
    logic [BW-1:0] pa, pb, pm, pc, pd, pe, pf;
    pa = 64'hA5A5_0001_5A5A_0001; pb = 64'h0123_4567_89AB_CDEF; pm = 64'hFF00_FF00_0F0F_F0F0;
    pc = 64'hC0DE_C0DE_1111_2222; pd = 64'hDDDD_0000_DDDD_0008; pe = 64'hEEEE_1234_EEEE_5678;
    pf = 64'hF00D_F00D_0000_0005;
    i_rd_req = 0; d_rd_req = 0; d_wr_req = 0;
    i_rd_addr = '0; d_rd_addr = '0; d_wr_addr = '0; d_wr_data = '0; d_wr_mask = '0;
    MEM_data_get = '0; MEM_data_read_done = 0; MEM_data_write_done = 0;
    wdat = '0; wmask = '0;
    for (int i = 0; i < 3; i++) begin a_addr[i] = '0; ref_last[i] = '0; end

    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_rd_en", int'(MEM_data_read_enable), 0);
    chk("rst_wr_en", int'(MEM_data_write_enable), 0);
    chk("rst_dones", int'(i_rd_done) + int'(d_rd_done) + int'(d_wr_done), 0);
    chk("rst_tmo", int'(timeout_err), 0);
    chkd("rst_i_data", i_rd_data, '0);
    chkd("rst_addr", BW'(MEM_data_read_address), '0);
    rst = 1'b1;

    // Single instr refill, MEM answers in the 6th enabled cycle.
    i_rd_req = 1; i_rd_addr = 32'h0000_0100;
    run_txn(6, pa, 0, who, wc, ec, ad, ww, tm, gv, mk);
    chk("t1_grant_latency", wc, 1);
    chk("t1_enable_cycles", ec, 6);
    chk("t1_who", who, 0);
    chkd("t1_addr", BW'(ad), 64'h100);
    chkd("t1_data", i_rd_data, pa);
    chk("t1_tmo", int'(tm), 0);
    exp_i = pa;
    i_rd_req = 0;
    @(negedge clk);
    chk("t1_busy_after", int'(busy), 0);

    // Both sides held continuously: data first after reset, then strict alternation.
    i_rd_req = 1; i_rd_addr = 32'h200; d_rd_req = 1; d_rd_addr = 32'h300;
    for (int k = 0; k < 4; k++) begin
      run_txn(2, pb ^ BW'(k), 0, who, wc, ec, ad, ww, tm, gv, mk);
      chk("t2_who", who, (k % 2 == 0) ? 1 : 0);
      chkd("t2_addr", BW'(ad), (k % 2 == 0) ? 64'h300 : 64'h200);
      if (k % 2 == 1) exp_i = pb ^ BW'(k);
    end
    i_rd_req = 0; d_rd_req = 0;
    @(negedge clk);

    // Writeback beats refill from the same data side.
    d_wr_req = 1; d_wr_addr = 32'h40; d_wr_data = pb; d_wr_mask = pm;
    d_rd_req = 1; d_rd_addr = 32'h40;
    run_txn(3, '0, 0, who, wc, ec, ad, ww, tm, gv, mk);
    chk("t3_wr_first", who, 2);
    chk("t3_is_write", int'(ww), 1);
    chkd("t3_give", gv, pb);
    chkd("t3_mask", mk, pm);
    d_wr_req = 0;
    run_txn(2, pc, 0, who, wc, ec, ad, ww, tm, gv, mk);
    chk("t3_rd_second", who, 1);
    chkd("t3_rd_data", d_rd_data, pc);
    d_rd_req = 0;
    @(negedge clk);

    // MEM never answers: abort after TMO enabled cycles, data untouched.
    i_rd_req = 1; i_rd_addr = 32'h800;
    run_txn(99, pe, 0, who, wc, ec, ad, ww, tm, gv, mk);
    chk("t4_enable_cycles", ec, TMO);
    chk("t4_tmo", int'(tm), 1);
    chk("t4_who", who, 0);
    chkd("t4_data_kept", i_rd_data, exp_i);
    i_rd_req = 0;
    @(negedge clk);
    chk("t4_busy_after", int'(busy), 0);
    chk("t4_tmo_after", int'(timeout_err), 0);

    // MEM done in the very last wait cycle is a normal completion.
    i_rd_req = 1;
    run_txn(TMO, pd, 0, who, wc, ec, ad, ww, tm, gv, mk);
    chk("t5_enable_cycles", ec, TMO);
    chk("t5_no_tmo", int'(tm), 0);
    chkd("t5_data", i_rd_data, pd);
    i_rd_req = 0;
    @(negedge clk);

    // A write done during a read is ignored.
    i_rd_req = 1;
    run_txn(4, pe, 1, who, wc, ec, ad, ww, tm, gv, mk);
    chk("t6_enable_cycles", ec, 4);
    chk("t6_who", who, 0);
    chkd("t6_data", i_rd_data, pe);
    i_rd_req = 0;
    @(negedge clk);

    // Reset in the middle of a read drops it silently.
    i_rd_req = 1;
    wc = 0;
    while (!MEM_data_read_enable && wc < 50) begin @(negedge clk); wc++; end
    repeat (2) @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("t7_rd_en_after_rst", int'(MEM_data_read_enable), 0);
    chk("t7_busy_after_rst", int'(busy), 0);
    rst = 1; i_rd_req = 0;
    ec = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      ec += int'(i_rd_done) + int'(d_rd_done) + int'(d_wr_done);
    end
    chk("t7_no_done", ec, 0);
    d_rd_req = 1; d_rd_addr = 32'h500;
    run_txn(2, pf, 0, who, wc, ec, ad, ww, tm, gv, mk);
    chk("t7_regrant_latency", wc, 1);
    chk("t7_regrant_who", who, 1);
    chkd("t7_regrant_data", d_rd_data, pf);
    d_rd_req = 0;

    // Randomized traffic from three independent requesters.
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    rst = 1;
    ref_last_data = 1'b0;
    for (int i = 0; i < 3; i++) ref_last[i] = '0;
    fork
      mem_model();
      monitor();
      begin
        fork
          agent(0);
          agent(1);
          agent(2);
        join
        repeat (30) @(negedge clk);
        stop = 1'b1;
      end
    join
    chk("sb_drained", sbq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
